tis_port_hub: RTL
=================

TIS_PORT_HUB -- requirements
Module: tis_port_hub

Interface
REQ-001 Parameter WORD_SIZE, default 11, data word width in bits.
REQ-002 Parameter NUM_PORTS, default 4, number of neighbour ports; PW = max(1,$clog2(NUM_PORTS)).
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 rd_req  in  1  node read request, held high until rd_done.
REQ-006 rd_mode  in  2  port_mode_t: PORT=0, ANY=1, LAST=2, NIL=3.
REQ-007 rd_port  in  PW  target port when rd_mode=PORT.
REQ-008 rd_done  out  1  one-cycle pulse, read complete.
REQ-009 rd_data  out  WORD_SIZE  read result, valid while rd_done=1.
REQ-010 wr_req / wr_mode / wr_port  in  1/2/PW  write request, mode and port, same semantics as read.
REQ-011 wr_data  in  WORD_SIZE  write data, sampled when the request is accepted.
REQ-012 wr_done  out  1  one-cycle pulse, write consumed.
REQ-013 in_valid / in_ready  in/out  NUM_PORTS  per-port inbound handshake; in_data in NUM_PORTS*WORD_SIZE, port p at [p*WORD_SIZE +: WORD_SIZE].
REQ-014 out_valid / out_ready  out/in  NUM_PORTS  per-port outbound handshake; out_data out WORD_SIZE shared by all ports.
REQ-015 last_port / last_vld  out  PW/1  port of the most recent ANY transfer, and its validity.

Function
REQ-016 Transfer on port p SHALL occur in a cycle with valid[p]&ready[p]; in_ready SHALL be registered, zero or one-hot.
REQ-017 Read and write SHALL use independent FSMs and may complete in the same cycle.
REQ-018 Read FSM states: R_IDLE, R_SCAN, R_WAIT, R_DONE; requests SHALL be sampled only in R_IDLE.
REQ-019 PORT read: R_IDLE->R_WAIT with in_ready[rd_port]=1; on transfer capture in_data, ->R_DONE; minimum latency: rd_done 2 cycles after rd_req.
REQ-020 ANY read: R_IDLE->R_SCAN with in_ready=0; when any in_valid is set, register the arbitration winner ->R_WAIT; if in_valid[winner] drops before transfer ->R_SCAN.
REQ-021 ANY transfer SHALL set last_port=winner and last_vld=1.
REQ-022 LAST with last_vld=1 SHALL behave as PORT on last_port; with last_vld=0, and for NIL, it SHALL behave as NIL.
REQ-023 NIL read SHALL go R_IDLE->R_DONE with rd_data=0; rd_port>=NUM_PORTS SHALL be treated as NIL.
REQ-024 R_DONE SHALL assert rd_done for one cycle, then ->R_IDLE.
REQ-025 Write FSM states: W_IDLE, W_WAIT, W_DONE; out_data SHALL be registered from wr_data on acceptance.
REQ-026 PORT write: out_valid[wr_port]=1 in W_WAIT until out_ready[wr_port], then ->W_DONE.
REQ-027 ANY write: out_valid[p] = W_WAIT & (no out_ready set | p = arbitration winner among out_ready); exactly one port transfers.
REQ-028 NIL write, or out-of-range port, SHALL discard data, ->W_DONE; W_DONE pulses wr_done, ->W_IDLE.
REQ-029 On simultaneous ANY read and ANY write transfers, the read port SHALL update last_port.
REQ-030 Arbitration SHALL select the lowest-index requesting port.

Reset
REQ-031 RST SHALL immediately force R_IDLE, W_IDLE, in_ready=0, out_valid=0, rd_done=0, wr_done=0, rd_data=0, out_data=0, last_port=0, last_vld=0, including mid-transfer.

Configuration
REQ-032 With TIS_ANY_RR_EN defined, arbitration SHALL be round-robin, searching from last_port+1 (from 0 when last_vld=0); without it, REQ-030 fixed priority applies.

Structure
REQ-033 port_mode_t and the NUM_PORTS default SHALL live in types_pkg beside src_t.
REQ-034 Arbitration SHALL be one sub-module, tis_port_arb, instantiated twice (read, write).

Verification
REQ-035 PORT read port 2, in_valid[2] held with data 0x155 -> in_ready[2] at cycle 1, rd_done with rd_data=0x155 at cycle 2.
REQ-036 ANY read, in_valid[1] and in_valid[3] rise together -> port 1 taken, last_port=1; with TIS_ANY_RR_EN a second ANY read takes port 3.
REQ-037 ANY write 0x7FF, out_ready[0] and out_ready[2] high -> out_valid only on port 0, one transfer, wr_done next cycle.
REQ-038 LAST read after reset -> rd_data=0, rd_done 1 cycle later, no in_ready asserted.
REQ-039 ANY read winner's in_valid drops before transfer -> return to R_SCAN, later take port 3 when in_valid[3] rises.
REQ-040 RST during W_WAIT -> out_valid=0 immediately, wr_done never pulses, next request accepted normally.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the TIS node: operand sources, port-access modes and the
// read/write FSM state encodings used by tis_port_hub.
package types_pkg;

    localparam int DEF_NUM_PORTS = 4;

    typedef enum logic [1:0] {
        SRC_ACC  = 2'd0,
        SRC_IMM  = 2'd1,
        SRC_NIL  = 2'd2,
        SRC_PORT = 2'd3
    } src_t;

    typedef enum logic [1:0] {
        PORT = 2'd0,
        ANY  = 2'd1,
        LAST = 2'd2,
        NIL  = 2'd3
    } port_mode_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_SCAN = 2'd1,
        R_WAIT = 2'd2,
        R_DONE = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_DONE = 2'd2
    } wr_state_t;

    // Collapse a requested mode to the three behaviours the FSMs implement:
    // LAST without history and out-of-range ports degrade to NIL.
    function automatic port_mode_t resolve_mode(input port_mode_t mode,
                                                input logic last_vld,
                                                input logic port_ok);
        port_mode_t eff;
        eff = NIL;
        case (mode)
            PORT:    eff = port_ok ? PORT : NIL;
            ANY:     eff = ANY;
            LAST:    eff = last_vld ? PORT : NIL;
            default: eff = NIL;
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/tis_port_arb.sv
// Port arbiter: lowest-index requester wins, or round-robin starting after
// last_port when TIS_ANY_RR_EN is defined.
module tis_port_arb
    import types_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        last_port,
    input  logic                 last_vld,
    output logic [PW-1:0]        grant,
    output logic                 found
);

`ifdef TIS_ANY_RR_EN
    logic [PW:0]          start;
    logic [NUM_PORTS-1:0] ge_mask;
    logic [NUM_PORTS-1:0] hi_req;

    // start may equal NUM_PORTS, which empties ge_mask and wraps to port 0
    assign start = last_vld ? ({1'b0, last_port} + 1'b1) : '0;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
        assign ge_mask[gi] = ((PW+1)'(gi) >= start);
    end

    assign hi_req = req & ge_mask;

    always_comb begin
        grant = '0;
        found = |req;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) grant = PW'(i);
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (hi_req[i]) grant = PW'(i);
        end
    end
`else
    logic unused_hist;
    assign unused_hist = ^{last_port, last_vld};

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                grant = PW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/tis_port_hub.sv
// Neighbour-port hub for a TIS node: independent read and write FSMs with
// PORT/ANY/LAST/NIL addressing. Define TIS_ANY_RR_EN for round-robin ANY.
module tis_port_hub
    import types_pkg::*;
#(
    parameter int WORD_SIZE = 11,
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_req,
    input  logic [1:0]                     rd_mode,
    input  logic [PW-1:0]                  rd_port,
    output logic                           rd_done,
    output logic [WORD_SIZE-1:0]           rd_data,
    input  logic                           wr_req,
    input  logic [1:0]                     wr_mode,
    input  logic [PW-1:0]                  wr_port,
    input  logic [WORD_SIZE-1:0]           wr_data,
    output logic                           wr_done,
    input  logic [NUM_PORTS-1:0]           in_valid,
    output logic [NUM_PORTS-1:0]           in_ready,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] in_data,
    output logic [NUM_PORTS-1:0]           out_valid,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [WORD_SIZE-1:0]           out_data,
    output logic [PW-1:0]                  last_port,
    output logic                           last_vld
);

    rd_state_t            rd_state;
    wr_state_t            wr_state;
    logic [PW-1:0]        rd_sel, wr_sel;
    logic                 rd_any, wr_any;
    logic [PW-1:0]        rd_tgt, wr_tgt, rd_win, wr_win;
    logic                 rd_found, wr_found;
    port_mode_t           rd_eff, wr_eff;
    logic [NUM_PORTS-1:0] rd_tgt_oh, rd_win_oh, wr_sel_oh, wr_win_oh;
    logic [WORD_SIZE-1:0] in_word [NUM_PORTS];
    logic                 rd_xfer, wr_xfer;

    assign rd_tgt = (port_mode_t'(rd_mode) == LAST) ? last_port : rd_port;
    assign wr_tgt = (port_mode_t'(wr_mode) == LAST) ? last_port : wr_port;
    assign rd_eff = resolve_mode(port_mode_t'(rd_mode), last_vld, int'(rd_port) < NUM_PORTS);
    assign wr_eff = resolve_mode(port_mode_t'(wr_mode), last_vld, int'(wr_port) < NUM_PORTS);

    tis_port_arb #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
        .req       (in_valid),
        .last_port (last_port),
        .last_vld  (last_vld),
        .grant     (rd_win),
        .found     (rd_found)
    );

    tis_port_arb #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
        .req       (out_ready),
        .last_port (last_port),
        .last_vld  (last_vld),
        .grant     (wr_win),
        .found     (wr_found)
    );

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign rd_tgt_oh[gi] = (rd_tgt == PW'(gi));
        assign rd_win_oh[gi] = (rd_win == PW'(gi));
        assign wr_sel_oh[gi] = (wr_sel == PW'(gi));
        assign wr_win_oh[gi] = (wr_win == PW'(gi));
        assign in_word[gi]   = in_data[gi*WORD_SIZE +: WORD_SIZE];
    end

    // ANY write offers to every port until one is ready, then only to the winner
    always_comb begin
        out_valid = '0;
        if (wr_state == W_WAIT) begin
            if (wr_any) out_valid = wr_found ? wr_win_oh : '1;
            else        out_valid = wr_sel_oh;
        end
    end

    assign rd_xfer = (rd_state == R_WAIT) && in_valid[rd_sel] && in_ready[rd_sel];
    assign wr_xfer = |(out_valid & out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            in_ready <= '0;
            rd_done  <= 1'b0;
            rd_data  <= '0;
            rd_sel   <= '0;
            rd_any   <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            unique case (rd_state)
                R_IDLE: begin
                    if (rd_req) begin
                        rd_any <= (rd_eff == ANY);
                        rd_sel <= rd_tgt;
                        case (rd_eff)
                            PORT: begin
                                in_ready <= rd_tgt_oh;
                                rd_state <= R_WAIT;
                            end
                            ANY: rd_state <= R_SCAN;
                            default: begin
                                rd_data  <= '0;
                                rd_done  <= 1'b1;
                                rd_state <= R_DONE;
                            end
                        endcase
                    end
                end
                R_SCAN: begin
                    if (rd_found) begin
                        rd_sel   <= rd_win;
                        in_ready <= rd_win_oh;
                        rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rd_xfer) begin
                        rd_data  <= in_word[rd_sel];
                        in_ready <= '0;
                        rd_done  <= 1'b1;
                        rd_state <= R_DONE;
                    end else if (rd_any && !in_valid[rd_sel]) begin
                        // winner withdrew its offer; re-arbitrate
                        in_ready <= '0;
                        rd_state <= R_SCAN;
                    end
                end
                R_DONE:  rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_done  <= 1'b0;
            out_data <= '0;
            wr_sel   <= '0;
            wr_any   <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            unique case (wr_state)
                W_IDLE: begin
                    if (wr_req) begin
                        wr_any <= (wr_eff == ANY);
                        wr_sel <= wr_tgt;
                        if (wr_eff == NIL) begin
                            wr_done  <= 1'b1;
                            wr_state <= W_DONE;
                        end else begin
                            out_data <= wr_data;
                            wr_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_xfer) begin
                        wr_done  <= 1'b1;
                        wr_state <= W_DONE;
                    end
                end
                W_DONE:  wr_state <= W_IDLE;
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read side wins when both FSMs complete an ANY transfer together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_port <= '0;
            last_vld  <= 1'b0;
        end else if (rd_xfer && rd_any) begin
            last_port <= rd_sel;
            last_vld  <= 1'b1;
        end else if (wr_xfer && wr_any) begin
            last_port <= wr_win;
            last_vld  <= 1'b1;
        end
    end

endmodule
